// File: rtl/ctr_drbg_update_seq_pkg.sv
// Shared definitions for the sequential CTR_DRBG Update engine.
//   upd_state_e : update FSM states
//   nblk()      : number of cipher blocks needed to cover the seed
//   ctr_incr()  : increments the low counter field of V, upper bits untouched
package ctr_drbg_pkg;

  // Widest V the counter helper handles; callers zero-extend / truncate.
  localparam int unsigned CTR_MAXW = 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINAL
  } upd_state_e;

  function automatic int unsigned nblk(input int unsigned seedlen,
                                       input int unsigned blocklen);
    return (seedlen + blocklen - 1) / blocklen;
  endfunction

  // Only bits below ctrlen take part in the increment; the carry out of the
  // counter field is dropped so the upper V bits never change.
  function automatic logic [CTR_MAXW-1:0] ctr_incr(input logic [CTR_MAXW-1:0] v,
                                                   input int unsigned ctrlen);
    logic [CTR_MAXW-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < CTR_MAXW; i++) begin
      if (i < ctrlen) mask[i] = 1'b1;
    end
    return (v & ~mask) | ((v + CTR_MAXW'(1)) & mask);
  endfunction

endpackage

// File: rtl/ctr_drbg_update_seq_if.sv
// Request/response bundle between the DRBG control logic and the Update engine.
//   master : requester (drives start and the operands, observes status/results)
//   slave  : Update engine
// Signals: start, provided_data[SEEDLEN], key_in[KEYLEN], v_in[BLOCKLEN],
//          busy, done, key_out[KEYLEN], v_out[BLOCKLEN]
interface ctr_drbg_update_seq_if #(
  parameter int unsigned BLOCKLEN = 128,
  parameter int unsigned KEYLEN   = 128,
  parameter int unsigned SEEDLEN  = 256
);
  logic                start;
  logic [SEEDLEN-1:0]  provided_data;
  logic [KEYLEN-1:0]   key_in;
  logic [BLOCKLEN-1:0] v_in;
  logic                busy;
  logic                done;
  logic [KEYLEN-1:0]   key_out;
  logic [BLOCKLEN-1:0] v_out;

  modport master (
    output start, provided_data, key_in, v_in,
    input  busy, done, key_out, v_out
  );

  modport slave (
    input  start, provided_data, key_in, v_in,
    output busy, done, key_out, v_out
  );
endinterface

// File: rtl/ctr_drbg_update_seq_block_enc.sv
// Fixed-latency block-encrypt unit for the CTR_DRBG Update engine.
// The transform is an interim XOR (out = v ^ key[BLOCKLEN-1:0]) to be replaced
// by AES with the same port and latency contract.
//   clk, rst   : clock, async active-high reset (clears the valid pipeline)
//   in_valid   : request strobe, key/v sampled on the same edge
//   out_valid  : result strobe, exactly ENC_LAT cycles after in_valid
//   out_block  : encrypted block
module ctr_drbg_block_enc #(
  parameter int unsigned BLOCKLEN = 128,
  parameter int unsigned KEYLEN   = 128,
  parameter int unsigned ENC_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [KEYLEN-1:0]   key,
  input  logic [BLOCKLEN-1:0] v,
  output logic                out_valid,
  output logic [BLOCKLEN-1:0] out_block
);

  logic [ENC_LAT-1:0]  vld_sr;
  logic [BLOCKLEN-1:0] blk_sr [ENC_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      for (int unsigned i = 0; i < ENC_LAT; i++) blk_sr[i] <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      blk_sr[0] <= v ^ key[BLOCKLEN-1:0];
      for (int unsigned i = 1; i < ENC_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        blk_sr[i] <= blk_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[ENC_LAT-1];
  assign out_block = blk_sr[ENC_LAT-1];

endmodule

// File: rtl/ctr_drbg_update_seq.sv
// Sequential CTR_DRBG Update: generates NBLK cipher blocks of incr(V) under
// Key, one at a time through ctr_drbg_block_enc, XORs the MSB-first
// concatenation with provided_data and returns the new Key and V.
//   clk, rst : clock, async active-high reset (aborts any update, no done)
//   bus      : slave side of ctr_drbg_update_seq_if
//              start accepted only while busy=0; operands captured at accept;
//              done is a one-cycle pulse, key_out/v_out held until next done;
//              busy covers every cycle from after accept through done.
module ctr_drbg_update_seq
  import ctr_drbg_pkg::*;
#(
  parameter int unsigned BLOCKLEN = 128,
  parameter int unsigned KEYLEN   = 128,
  parameter int unsigned SEEDLEN  = 256,
  parameter int unsigned CTRLEN   = 32,
  parameter int unsigned ENC_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ctr_drbg_update_seq_if.slave  bus
);

  localparam int unsigned NBLK  = nblk(SEEDLEN, BLOCKLEN);
  localparam int unsigned TEMPW = NBLK * BLOCKLEN;
  localparam int unsigned CNTW  = $clog2(NBLK + 1);

  if (SEEDLEN != KEYLEN + BLOCKLEN) begin : g_chk_seedlen
    $error("ctr_drbg_update_seq: SEEDLEN must equal KEYLEN+BLOCKLEN");
  end
  if (KEYLEN < BLOCKLEN) begin : g_chk_keylen
    $error("ctr_drbg_update_seq: KEYLEN must be >= BLOCKLEN");
  end
  if (CTRLEN < 4 || CTRLEN > BLOCKLEN) begin : g_chk_ctrlen
    $error("ctr_drbg_update_seq: CTRLEN must be in 4..BLOCKLEN");
  end
  if (ENC_LAT < 1) begin : g_chk_enc_lat
    $error("ctr_drbg_update_seq: ENC_LAT must be >= 1");
  end
  if (BLOCKLEN > CTR_MAXW) begin : g_chk_blocklen
    $error("ctr_drbg_update_seq: BLOCKLEN exceeds counter helper width");
  end

  upd_state_e state, state_nxt;

  logic                accept, issue, store, finish;
  logic [CNTW-1:0]     blk_cnt;
  logic [KEYLEN-1:0]   key_reg;
  logic [BLOCKLEN-1:0] v_reg;
  logic [BLOCKLEN-1:0] v_inc;
  logic [SEEDLEN-1:0]  pd_reg;
  logic [TEMPW-1:0]    temp;
  logic [SEEDLEN-1:0]  seed_xor;
  logic                done_q;
  logic [KEYLEN-1:0]   key_out_q;
  logic [BLOCKLEN-1:0] v_out_q;
  logic                enc_out_valid;
  logic [BLOCKLEN-1:0] enc_out_block;

  // Busy stays high through the done cycle, which is spent back in IDLE.
  assign bus.busy    = (state != IDLE) || done_q;
  assign bus.done    = done_q;
  assign bus.key_out = key_out_q;
  assign bus.v_out   = v_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    store     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.busy) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (enc_out_valid) begin
          store     = 1'b1;
          state_nxt = (blk_cnt == CNTW'(NBLK - 1)) ? FINAL : ISSUE;
        end
      end
      FINAL: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    v_inc = BLOCKLEN'(ctr_incr(CTR_MAXW'(v_reg), CTRLEN));
  end

  // Excess low bits of the block concatenation are dropped, keeping the
  // leftmost SEEDLEN bits.
  always_comb begin
    seed_xor = temp[TEMPW-1 -: SEEDLEN] ^ pd_reg;
  end

  ctr_drbg_block_enc #(
    .BLOCKLEN (BLOCKLEN),
    .KEYLEN   (KEYLEN),
    .ENC_LAT  (ENC_LAT)
  ) u_enc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .key       (key_reg),
    .v         (v_inc),
    .out_valid (enc_out_valid),
    .out_block (enc_out_block)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt   <= '0;
      key_reg   <= '0;
      v_reg     <= '0;
      pd_reg    <= '0;
      temp      <= '0;
      done_q    <= 1'b0;
      key_out_q <= '0;
      v_out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        key_reg <= bus.key_in;
        v_reg   <= bus.v_in;
        pd_reg  <= bus.provided_data;
        blk_cnt <= '0;
        temp    <= '0;
      end
      if (issue) v_reg <= v_inc;
      if (store) begin
        // Shifting each block in at the bottom lands block k in slot k
        // (block 0 at the top) once all NBLK blocks have arrived.
        temp    <= {temp[TEMPW-BLOCKLEN-1:0], enc_out_block};
        blk_cnt <= blk_cnt + CNTW'(1);
      end
      if (finish) begin
        key_out_q <= seed_xor[SEEDLEN-1 -: KEYLEN];
        v_out_q   <= seed_xor[BLOCKLEN-1:0];
        done_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctr_drbg_update_seq.sv
module tb_ctr_drbg_update_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  ctr_drbg_update_seq_if #(.BLOCKLEN(128), .KEYLEN(128), .SEEDLEN(256)) bus_a ();
  ctr_drbg_update_seq_if #(.BLOCKLEN(128), .KEYLEN(256), .SEEDLEN(384)) bus_b ();

  ctr_drbg_update_seq #(
    .BLOCKLEN(128), .KEYLEN(128), .SEEDLEN(256), .CTRLEN(32), .ENC_LAT(2)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  ctr_drbg_update_seq #(
    .BLOCKLEN(128), .KEYLEN(256), .SEEDLEN(384), .CTRLEN(32), .ENC_LAT(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference Update: returns {new_key (right-aligned in 256), new_v}.
  function automatic logic [383:0] model_update(input logic [255:0] key,
                                                input logic [127:0] v,
                                                input logic [383:0] pd,
                                                input int keylen);
    int seedlen;
    int nb;
    logic [511:0] stream;
    logic [127:0] vv;
    logic [383:0] seed;
    seedlen = keylen + 128;
    nb      = (seedlen + 127) / 128;
    stream  = '0;
    vv      = v;
    for (int b = 0; b < nb; b++) begin
      vv[31:0] = vv[31:0] + 32'd1;
      stream   = (stream << 128) | {384'h0, vv ^ key[127:0]};
    end
    stream = stream >> (nb * 128 - seedlen);
    seed   = stream[383:0] ^ pd;
    return {128'h0, seed[383:128], seed[127:0]} >> 0;
  endfunction

  function automatic logic [383:0] rnd();
    logic [383:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r = {r[351:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic get_busy(input bit use_b);
    return use_b ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic get_done(input bit use_b);
    return use_b ? bus_b.done : bus_a.done;
  endfunction

  function automatic logic [383:0] get_result(input bit use_b);
    return use_b ? {bus_b.key_out, bus_b.v_out} : {128'h0, bus_a.key_out, bus_a.v_out};
  endfunction

  task automatic drive(input bit use_b, input bit st, input logic [255:0] key,
                       input logic [127:0] v, input logic [383:0] pd);
    if (use_b) begin
      bus_b.start = st; bus_b.key_in = key; bus_b.v_in = v; bus_b.provided_data = pd;
    end else begin
      bus_a.start = st; bus_a.key_in = key[127:0]; bus_a.v_in = v; bus_a.provided_data = pd[255:0];
    end
  endtask

  // Called at a negedge with the DUT idle; start is raised in this cycle so
  // the following posedge is the accepting edge (cycle 0 afterwards).
  task automatic run(input string tag, input bit use_b, input logic [255:0] key,
                     input logic [127:0] v, input logic [383:0] pd);
    logic [383:0] exp;
    logic [255:0] k;
    logic [383:0] p;
    int lat;
    int exp_lat;
    bit busy_ok;
    k = use_b ? key : {128'h0, key[127:0]};
    p = use_b ? pd  : {128'h0, pd[255:0]};
    exp     = model_update(k, v, p, use_b ? 256 : 128);
    exp_lat = use_b ? 10 : 7;
    drive(use_b, 1'b1, k, v, p);
    @(negedge clk);
    drive(use_b, 1'b0, ~k, ~v, ~p);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (get_busy(use_b) !== 1'b1) busy_ok = 1'b0;
      if (get_done(use_b) === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check({tag, ":latency"}, 384'(lat), 384'(exp_lat));
    check({tag, ":busy"}, {383'h0, busy_ok}, 384'h1);
    check({tag, ":result"}, get_result(use_b), exp);
    @(negedge clk);
    check({tag, ":after"}, {382'h0, get_busy(use_b), get_done(use_b)}, 384'h0);
  endtask

  initial begin
    logic [383:0] r1, r2, r3;
    int dones;
    int first_done;

    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset_a", {bus_a.busy, bus_a.done, bus_a.key_out, bus_a.v_out}, 384'h0);
    check("reset_b", {bus_b.busy, bus_b.done, bus_b.key_out, bus_b.v_out}, 384'h0);
    rst = 1'b0;
    @(negedge clk);

    run("zeros_a", 1'b0, '0, '0, '0);
    check("zeros_a:const", {256'h0, bus_a.key_out}, {256'h0, 128'h1});
    check("zeros_a:const_v", {256'h0, bus_a.v_out}, {256'h0, 128'h2});
    run("pd_a", 1'b0, '0, '0, {128'h0, 128'hFF, 128'h0F});
    check("pd_a:const", {bus_a.key_out, bus_a.v_out}, {128'hFE, 128'h0D});
    run("wrap_a", 1'b0, '0, {{12{8'hA5}}, 32'hFFFF_FFFF}, '0);
    check("wrap_a:const", {bus_a.key_out, bus_a.v_out},
          {{12{8'hA5}}, 32'h0, {12{8'hA5}}, 32'h1});
    run("zeros_b", 1'b1, '0, '0, '0);
    check("zeros_b:const", {bus_b.key_out, bus_b.v_out}, {128'h1, 128'h2, 128'h3});

    // start re-raised mid-operation with other operands must be ignored
    r1 = rnd(); r2 = rnd(); r3 = rnd();
    drive(1'b0, 1'b1, r1[255:0], r2[127:0], r3);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    dones = 0;
    first_done = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) drive(1'b0, 1'b1, ~r1[255:0], ~r2[127:0], ~r3);
      if (c == 4) drive(1'b0, 1'b0, '0, '0, '0);
      if (bus_a.done === 1'b1) begin
        dones++;
        if (first_done < 0) begin
          first_done = c;
          check("ignore:result", get_result(1'b0),
                model_update({128'h0, r1[127:0]}, r2[127:0], {128'h0, r3[255:0]}, 128));
        end
      end
      @(negedge clk);
    end
    check("ignore:first_done", 384'(first_done), 384'(7));
    check("ignore:pulses", 384'(dones), 384'(1));

    for (int i = 0; i < 16; i++) begin
      r1 = rnd(); r2 = rnd(); r3 = rnd();
      if (i % 4 == 0) r2[31:0] = 32'hFFFF_FFFF;
      run($sformatf("rand_a%0d", i), 1'b0, r1[255:0], r2[127:0], r3);
    end
    for (int i = 0; i < 8; i++) begin
      r1 = rnd(); r2 = rnd(); r3 = rnd();
      if (i % 3 == 0) r2[31:0] = 32'hFFFF_FFFE;
      run($sformatf("rand_b%0d", i), 1'b1, r1[255:0], r2[127:0], r3);
    end

    // asynchronous reset in the middle of an update
    r1 = rnd(); r2 = rnd(); r3 = rnd();
    drive(1'b0, 1'b1, r1[255:0], r2[127:0], r3);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_a", {bus_a.busy, bus_a.done, bus_a.key_out, bus_a.v_out}, 384'h0);
    check("midrst_b", {bus_b.busy, bus_b.done, bus_b.key_out, bus_b.v_out}, 384'h0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus_a.done === 1'b1) dones++;
      @(negedge clk);
    end
    check("midrst:no_done", 384'(dones), 384'(0));
    r1 = rnd(); r2 = rnd(); r3 = rnd();
    run("after_rst_a", 1'b0, r1[255:0], r2[127:0], r3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
